// File: rtl/img_stream_ctrl.sv
// Pixel stream tagger between the image DMA and the multiplier array: tags each beat
// with {chan, row, col} behind a registered output slice. Optional checking: IMG_STREAM_CTRL_ERR_EN.
module img_stream_ctrl #(
    parameter int I_DIM  = 8,
    parameter int C_CNT  = 1,
    parameter int M_BITS = 16,
    parameter int I_BITS = $clog2(I_DIM + 1),
    parameter int C_BITS = (C_CNT > 1) ? $clog2(C_CNT + 1) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [I_BITS-1:0]         cfg_rows,
    input  logic [I_BITS-1:0]         cfg_cols,
    input  logic [C_BITS-1:0]         cfg_chans,
    input  logic [M_BITS-1:0]         in_data,
    input  logic                      in_last,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [M_BITS-1:0]         out_data,
    output logic [C_BITS+2*I_BITS-1:0] out_user,
    output logic                      out_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy,
    output logic [1:0]                err,
    input  logic                      err_clr
);

    localparam int                U_BITS   = C_BITS + 2 * I_BITS;
    localparam logic [I_BITS-1:0] DIM_MAX  = I_BITS'(I_DIM - 1);
    localparam logic [C_BITS-1:0] CHAN_MAX = C_BITS'(C_CNT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_n;

    logic [I_BITS-1:0] rows_q, rows_n, cols_q, cols_n;
    logic [C_BITS-1:0] chans_q, chans_n;
    logic [I_BITS-1:0] x_q, x_n, y_q, y_n;
    logic [C_BITS-1:0] c_q, c_n;

    logic [M_BITS-1:0] data_q, data_n;
    logic [U_BITS-1:0] user_q, user_n;
    logic              last_q, last_n;
    logic              valid_q, valid_n;
    logic [1:0]        err_q, err_n;

    logic [I_BITS-1:0] rows_eff, cols_eff;
    logic [C_BITS-1:0] chans_eff;
    logic              accept, load, final_pix, early_last, missing_last, frame_end;

    function automatic logic [I_BITS-1:0] clamp_dim(input logic [I_BITS-1:0] v);
        return (v > DIM_MAX) ? DIM_MAX : v;
    endfunction

    function automatic logic [C_BITS-1:0] clamp_chan(input logic [C_BITS-1:0] v);
        return (v > CHAN_MAX) ? CHAN_MAX : v;
    endfunction

    // In IDLE the frame has not been latched yet, so the first beat uses the live cfg.
    assign rows_eff  = (state == IDLE) ? clamp_dim(cfg_rows)   : rows_q;
    assign cols_eff  = (state == IDLE) ? clamp_dim(cfg_cols)   : cols_q;
    assign chans_eff = (state == IDLE) ? clamp_chan(cfg_chans) : chans_q;

    assign in_ready  = (state == DRAIN) || !valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign load      = accept && (state != DRAIN);
    assign final_pix = (c_q == chans_eff) && (x_q == cols_eff) && (y_q == rows_eff);

`ifdef IMG_STREAM_CTRL_ERR_EN
    assign early_last   = in_last && !final_pix;
    assign missing_last = !in_last && final_pix;
`else
    assign early_last   = 1'b0;
    assign missing_last = 1'b0;
    logic unused_inputs;
    assign unused_inputs = &{1'b0, in_last, err_clr};
`endif

    assign frame_end = final_pix || early_last;

    // NOTE: every variable gets its default first, so no path through this block infers a latch.
    always_comb begin
        state_n = state;
        rows_n  = rows_q;
        cols_n  = cols_q;
        chans_n = chans_q;
        c_n     = c_q;
        x_n     = x_q;
        y_n     = y_q;
        data_n  = data_q;
        user_n  = user_q;
        last_n  = last_q;
        valid_n = valid_q;
        err_n   = err_q;

        if (valid_q && out_ready) begin
            valid_n = 1'b0;
        end

        if (load) begin
            valid_n = 1'b1;
            data_n  = in_data;
            user_n  = {c_q, y_q, x_q};
            last_n  = frame_end;

            if (state == IDLE) begin
                rows_n  = rows_eff;
                cols_n  = cols_eff;
                chans_n = chans_eff;
            end

            if (frame_end) begin
                c_n = '0;
                x_n = '0;
                y_n = '0;
            end else if (c_q != chans_eff) begin
                c_n = c_q + 1'b1;
            end else begin
                c_n = '0;
                if (x_q != cols_eff) begin
                    x_n = x_q + 1'b1;
                end else begin
                    x_n = '0;
                    y_n = y_q + 1'b1;
                end
            end

            if (frame_end) begin
                state_n = missing_last ? DRAIN : IDLE;
            end else begin
                state_n = RUN;
            end
        end

`ifdef IMG_STREAM_CTRL_ERR_EN
        // Surplus beats after a missing in_last are swallowed up to and including in_last.
        if (state == DRAIN && accept && in_last) begin
            state_n = IDLE;
        end

        if (err_clr) begin
            err_n = 2'b00;
        end
        if (load && early_last) begin
            err_n[0] = 1'b1;
        end
        if (load && missing_last) begin
            err_n[1] = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // NOTE: the payload registers are reset too, so a mid-frame reset leaves no stale beat visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            rows_q  <= '0;
            cols_q  <= '0;
            chans_q <= '0;
            c_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            data_q  <= '0;
            user_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 2'b00;
        end else begin
            rows_q  <= rows_n;
            cols_q  <= cols_n;
            chans_q <= chans_n;
            c_q     <= c_n;
            x_q     <= x_n;
            y_q     <= y_n;
            data_q  <= data_n;
            user_q  <= user_n;
            last_q  <= last_n;
            valid_q <= valid_n;
            err_q   <= err_n;
        end
    end

    assign out_data  = data_q;
    assign out_user  = user_q;
    assign out_last  = last_q;
    assign out_valid = valid_q;
    assign busy      = (state != IDLE);
    assign err       = err_q;

endmodule

// File: tb/tb_img_stream_ctrl.sv
// Self-checking bench for img_stream_ctrl: a frame-position model checked every cycle,
// plus directed frames with hand-computed tags. Error-path tests need IMG_STREAM_CTRL_ERR_EN.
module tb_img_stream_ctrl;

    localparam int ID = 8;
    localparam int CC = 4;
    localparam int MB = 16;
    localparam int IB = 4;
    localparam int CB = 3;
    localparam int UB = CB + 2 * IB;
`ifdef IMG_STREAM_CTRL_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [IB-1:0] cfg_rows, cfg_cols;
    logic [CB-1:0] cfg_chans;
    logic [MB-1:0] in_data;
    logic          in_last, in_valid, in_ready;
    logic [MB-1:0] out_data;
    logic [UB-1:0] out_user;
    logic          out_last, out_valid, out_ready, busy, err_clr;
    logic [1:0]    err;

    img_stream_ctrl #(
        .I_DIM(ID), .C_CNT(CC), .M_BITS(MB), .I_BITS(IB), .C_BITS(CB)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_rows(cfg_rows), .cfg_cols(cfg_cols), .cfg_chans(cfg_chans),
        .in_data(in_data), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_user(out_user), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .err(err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;
    int rdy_mode = 0;

    typedef struct {
        logic [UB-1:0] user;
        logic          last;
        logic [MB-1:0] data;
        int            cyc;
    } beat_t;
    beat_t cap[$];

    // Model: frame position counter and latched frame dimensions.
    bit            m_ov, m_busy, m_drain, m_last;
    logic [MB-1:0] m_data;
    logic [UB-1:0] m_user;
    logic [1:0]    m_err;
    int            m_pos, m_ch, m_cols, m_rows;

    logic [UB-1:0] t1_user [4] = '{11'h000, 11'h001, 11'h010, 11'h011};
    logic [UB-1:0] t2_user [6] = '{11'h000, 11'h100, 11'h200, 11'h001, 11'h101, 11'h201};
    logic [3:0]    rdy_pat     = 4'b1001;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [UB-1:0] pack(input int c, input int y, input int x);
        return {CB'(c), IB'(y), IB'(x)};
    endfunction

    task automatic step_model();
        bit         rdy, acc, fin, lst;
        logic [1:0] set;
        int         total;
        rdy = m_drain || !m_ov || out_ready;
        acc = in_valid && rdy;
        set = 2'b00;
        if (rst) begin
            m_ov = 0; m_busy = 0; m_drain = 0; m_last = 0;
            m_data = '0; m_user = '0; m_err = 2'b00; m_pos = 0;
            return;
        end
        if (!acc || m_drain) begin
            if (out_ready) m_ov = 0;
        end
        if (acc && m_drain) begin
            if (in_last) m_drain = 0;
        end else if (acc) begin
            if (!m_busy) begin
                m_rows = ((cfg_rows  > ID - 1) ? ID - 1 : int'(cfg_rows))  + 1;
                m_cols = ((cfg_cols  > ID - 1) ? ID - 1 : int'(cfg_cols))  + 1;
                m_ch   = ((cfg_chans > CC - 1) ? CC - 1 : int'(cfg_chans)) + 1;
                m_pos  = 0;
            end
            total  = m_ch * m_cols * m_rows;
            fin    = (m_pos == total - 1);
            lst    = ERR && in_last;
            m_ov   = 1;
            m_data = in_data;
            m_user = pack(m_pos % m_ch, m_pos / (m_ch * m_cols), (m_pos / m_ch) % m_cols);
            m_last = fin || lst;
            if (fin) begin
                m_busy = 0;
                if (ERR && !in_last) begin
                    m_drain = 1;
                    set[1]  = 1'b1;
                end
            end else if (lst) begin
                m_busy = 0;
                set[0] = 1'b1;
            end else begin
                m_busy = 1;
                m_pos++;
            end
        end
        if (ERR) m_err = (err_clr ? 2'b00 : m_err) | set;
    endtask

    initial begin
        m_ov = 0; m_busy = 0; m_drain = 0; m_last = 0; m_data = '0; m_user = '0;
        m_err = 2'b00; m_pos = 0; m_ch = 1; m_cols = 1; m_rows = 1;
        forever begin
            @(posedge clk);
            cyc++;
            step_model();
        end
    end

    // Compare process: checks the DUT against the model in the middle of every cycle.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("out_valid", out_valid, m_ov);
            check("in_ready", in_ready, m_drain || !m_ov || out_ready);
            check("busy", busy, m_busy || m_drain);
            check("err", err, m_err);
            if (m_ov) begin
                check("out_data", out_data, m_data);
                check("out_user", out_user, m_user);
                check("out_last", out_last, m_last);
            end
            if (out_valid && out_ready) begin
                cap.push_back('{user: out_user, last: out_last, data: out_data, cyc: cyc});
            end
        end
    end

    initial begin
        int k;
        k = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            k++;
            out_ready = (rdy_mode == 0) ? 1'b1 : rdy_pat[k % 4];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic set_cfg(input int r, input int c, input int ch);
        cfg_rows  = IB'(r);
        cfg_cols  = IB'(c);
        cfg_chans = CB'(ch);
    endtask

    task automatic send_beat(input logic [MB-1:0] d, input bit l);
        int t;
        bit done;
        t = 0;
        done = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!done) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
            t++;
            if (!done && t > 50) begin
                n_checks++;
                n_fail++;
                $display("FAIL send_timeout: in_ready stayed %0b for %0d cycles, required 1", in_ready, t);
                done = 1;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input int n, input int last_at, input logic [MB-1:0] base);
        for (int i = 1; i <= n; i++) send_beat(base + MB'(i - 1), i == last_at);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((m_ov || m_drain) && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain_timeout", t < 100, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; err_clr = 1'b0;
        set_cfg(0, 0, 0);
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_out_user", out_user, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 2x2, one channel, full throughput.
        cap.delete();
        set_cfg(1, 1, 0);
        send_frame(4, 4, 16'h1000);
        wait_drain();
        check("t1_count", cap.size(), 4);
        for (int i = 0; i < cap.size() && i < 4; i++) begin
            check("t1_user", cap[i].user, t1_user[i]);
            check("t1_last", cap[i].last, i == 3);
        end
        check("t1_back_to_back", cap[3].cyc - cap[0].cyc, 3);

        // Three channels across two columns.
        cap.delete();
        set_cfg(0, 1, 2);
        send_frame(6, 6, 16'h2000);
        wait_drain();
        check("t2_count", cap.size(), 6);
        for (int i = 0; i < cap.size() && i < 6; i++) begin
            check("t2_user", cap[i].user, t2_user[i]);
            check("t2_last", cap[i].last, i == 5);
        end

        // 3x3 under backpressure; cfg is changed after the first beat and must be ignored.
        cap.delete();
        rdy_mode = 1;
        set_cfg(2, 2, 0);
        send_beat(16'h3000, 1'b0);
        set_cfg(0, 0, 0);
        for (int i = 1; i < 9; i++) send_beat(16'h3000 + MB'(i), i == 8);
        wait_drain();
        rdy_mode = 0;
        check("t3_count", cap.size(), 9);
        for (int i = 0; i < cap.size() && i < 9; i++) begin
            check("t3_data", cap[i].data, 16'h3000 + i);
            check("t3_user", cap[i].user, (i / 3) * 16 + (i % 3));
        end

        // Oversized cfg clamps to 4 channels x 8 cols x 1 row.
        cap.delete();
        set_cfg(0, 12, 5);
        send_frame(32, 32, 16'h4000);
        wait_drain();
        check("t4_count", cap.size(), 32);
        check("t4_user3", cap[3].user, 11'h300);
        check("t4_user4", cap[4].user, 11'h001);
        check("t4_user31", cap[31].user, 11'h307);
        check("t4_last31", cap[31].last, 1);
        check("t4_last30", cap[30].last, 0);

`ifdef IMG_STREAM_CTRL_ERR_EN
        // Early in_last on beat 5 of a 3x3 frame.
        cap.delete();
        set_cfg(2, 2, 0);
        send_frame(5, 5, 16'h5000);
        wait_drain();
        check("t5_count", cap.size(), 5);
        check("t5_last", cap[4].last, 1);
        check("t5_user", cap[4].user, 11'h011);
        check("t5_err", err, 2'b01);
        cap.delete();
        set_cfg(1, 1, 0);
        send_frame(4, 4, 16'h5100);
        wait_drain();
        check("t5_next_user", cap[0].user, 11'h000);
        check("t5_next_count", cap.size(), 4);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        @(negedge clk);
        check("t5_err_clr", err, 2'b00);

        // Missing in_last: 6 beats into a 2x2 frame.
        cap.delete();
        send_frame(6, 6, 16'h6000);
        wait_drain();
        check("t6_count", cap.size(), 4);
        check("t6_last", cap[3].last, 1);
        check("t6_err", err, 2'b10);
        check("t6_busy", busy, 0);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        @(negedge clk);
        check("t6_err_clr", err, 2'b00);
        @(posedge clk);
        #1;
`endif

        // Reset three beats into a 4x4 frame.
        set_cfg(3, 3, 0);
        send_frame(3, 0, 16'h7000);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("t7_out_valid", out_valid, 0);
        check("t7_busy", busy, 0);
        check("t7_out_user", out_user, 0);
        @(posedge clk);
        #1;
        cap.delete();
        set_cfg(1, 1, 0);
        send_frame(4, 4, 16'h7100);
        wait_drain();
        check("t7_count", cap.size(), 4);
        check("t7_first_user", cap[0].user, 11'h000);
        check("t7_first_data", cap[0].data, 16'h7100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
